// File: rtl/regfile_bus_fabric.sv
// General register file, program counter and two internal buses with a multiplexed address pin port.
// Optional sticky bus-contention flag is built only when REGFILE_CONTENTION_DETECT_EN is defined.
module regfile_bus_fabric #(
    parameter int                 WIDTH    = 8,
    parameter int                 NUM_REGS = 3,
    parameter logic [2*WIDTH-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk_enable,
    input  logic [3*NUM_REGS-1:0]     reg_enable,
    input  logic                      latch_valid,
    input  logic [WIDTH-1:0]          latch_data,
    input  logic                      alu_valid,
    input  logic [WIDTH-1:0]          alu_result,
    input  logic [1:0]                pc_op,
    output logic [WIDTH-1:0]          bus1,
    output logic [WIDTH-1:0]          bus2,
    output logic [NUM_REGS*WIDTH-1:0] reg_out,
    output logic [2*WIDTH-1:0]        pc,
    output logic                      phase,
    output logic [WIDTH-1:0]          addr_pins,
    output logic                      contention
);

    localparam int AW = 2 * WIDTH;

    localparam logic [2:0] CODE_LOAD1  = 3'b100;
    localparam logic [2:0] CODE_LOAD2  = 3'b101;
    localparam logic [2:0] CODE_STORE1 = 3'b110;
    localparam logic [2:0] CODE_STORE2 = 3'b111;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_LOAD = 2'b10;
    localparam logic [1:0] PC_REL  = 2'b11;

    // No handshake: decode holds reg_enable/pc_op stable across every enabled edge,
    // and the buses are pure combinational functions of those codes and the state.

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [AW-1:0]    pc_q;
    logic [AW-1:0]    pc_next;
    logic             phase_q;
    logic [WIDTH-1:0] bus1_sel;
    logic [WIDTH-1:0] bus2_sel;

    // Fixed priority: external source first, then the lowest-index storing register.
    always_comb begin
        logic bus1_hit;
        logic bus2_hit;
        bus1_sel = '0;
        bus2_sel = '0;
        bus1_hit = latch_valid;
        bus2_hit = alu_valid;
        if (latch_valid) bus1_sel = latch_data;
        if (alu_valid)   bus2_sel = alu_result;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!bus1_hit && reg_enable[3*i +: 3] == CODE_STORE1) begin
                bus1_sel = regs[i];
                bus1_hit = 1'b1;
            end
            if (!bus2_hit && reg_enable[3*i +: 3] == CODE_STORE2) begin
                bus2_sel = regs[i];
                bus2_hit = 1'b1;
            end
        end
    end

    always_comb begin
        pc_next = pc_q;
        case (pc_op)
            PC_HOLD: pc_next = pc_q;
            PC_INC:  pc_next = pc_q + {{(AW-1){1'b0}}, 1'b1};
            PC_LOAD: pc_next = {bus2_sel, bus1_sel};
            PC_REL:  pc_next = pc_q + {{WIDTH{bus1_sel[WIDTH-1]}}, bus1_sel};
            default: pc_next = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            pc_q    <= RESET_PC;
            phase_q <= 1'b0;
        end else if (clk_enable) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                case (reg_enable[3*i +: 3])
                    CODE_LOAD1: regs[i] <= bus1_sel;
                    CODE_LOAD2: regs[i] <= bus2_sel;
                    default:    ;
                endcase
            end
            pc_q    <= pc_next;
            phase_q <= ~phase_q;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[WIDTH*g +: WIDTH] = regs[g];
    end

    assign bus1      = bus1_sel;
    assign bus2      = bus2_sel;
    assign pc        = pc_q;
    assign phase     = phase_q;
    assign addr_pins = phase_q ? pc_q[AW-1:WIDTH] : pc_q[WIDTH-1:0];

`ifdef REGFILE_CONTENTION_DETECT_EN
    logic contention_q;
    logic clash;

    always_comb begin
        int n1;
        int n2;
        n1 = latch_valid ? 1 : 0;
        n2 = alu_valid ? 1 : 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_enable[3*i +: 3] == CODE_STORE1) n1 = n1 + 1;
            if (reg_enable[3*i +: 3] == CODE_STORE2) n2 = n2 + 1;
        end
        clash = (n1 > 1) || (n2 > 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                  contention_q <= 1'b0;
        else if (clk_enable && clash) contention_q <= 1'b1;
    end

    assign contention = contention_q;
`else
    assign contention = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_bus_fabric.sv
// Directed bench for regfile_bus_fabric: register transfers, PC ops, pin mux, contention and reset.
module tb_regfile_bus_fabric;

    localparam int          WIDTH    = 8;
    localparam int          NUM_REGS = 3;
    localparam logic [15:0] RST_PC   = 16'hFFFC;
`ifdef REGFILE_CONTENTION_DETECT_EN
    localparam logic EXP_CONT = 1'b1;
`else
    localparam logic EXP_CONT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_enable;
    logic [8:0]  reg_enable;
    logic        latch_valid;
    logic [7:0]  latch_data;
    logic        alu_valid;
    logic [7:0]  alu_result;
    logic [1:0]  pc_op;
    logic [7:0]  bus1;
    logic [7:0]  bus2;
    logic [23:0] reg_out;
    logic [15:0] pc;
    logic        phase;
    logic [7:0]  addr_pins;
    logic        contention;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic exp_phase = 1'b0;

    regfile_bus_fabric #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .reg_enable(reg_enable),
        .latch_valid(latch_valid), .latch_data(latch_data), .alu_valid(alu_valid),
        .alu_result(alu_result), .pc_op(pc_op), .bus1(bus1), .bus2(bus2),
        .reg_out(reg_out), .pc(pc), .phase(phase), .addr_pins(addr_pins),
        .contention(contention)
    );

    always #5 clk = ~clk;

    // One clock edge; the phase model follows reset and clk_enable, then outputs settle.
    task automatic step();
        @(posedge clk);
        if (!rst_n)          exp_phase = 1'b0;
        else if (clk_enable) exp_phase = ~exp_phase;
        #1;
    endtask

    task automatic idle_inputs();
        reg_enable  = 9'b000_000_000;
        latch_valid = 1'b0;
        latch_data  = 8'h00;
        alu_valid   = 1'b0;
        alu_result  = 8'h00;
        pc_op       = 2'b00;
    endtask

    task automatic test_reset();
        idle_inputs();
        clk_enable  = 1'b1;
        rst_n       = 1'b0;
        reg_enable  = 9'b100_100_100;
        latch_valid = 1'b1;
        latch_data  = 8'hEE;
        pc_op       = 2'b01;
        step();
        step();
        idle_inputs();
        rst_n = 1'b1;
        #1;
        total_cnt++; if (reg_out !== 24'h000000) $display("FAIL reset_regs got %h want %h", reg_out, 24'h000000); else pass_cnt++;
        total_cnt++; if (pc !== RST_PC) $display("FAIL reset_pc got %h want %h", pc, RST_PC); else pass_cnt++;
        total_cnt++; if (phase !== 1'b0) $display("FAIL reset_phase got %b want 0", phase); else pass_cnt++;
        total_cnt++; if (addr_pins !== 8'hFC) $display("FAIL reset_addr_pins got %h want fc", addr_pins); else pass_cnt++;
        total_cnt++; if (bus1 !== 8'h00 || bus2 !== 8'h00) $display("FAIL reset_buses got %h/%h want 00/00", bus1, bus2); else pass_cnt++;
        total_cnt++; if (contention !== 1'b0) $display("FAIL reset_contention got %b want 0", contention); else pass_cnt++;
    endtask

    task automatic test_latch_load();
        latch_valid = 1'b1;
        latch_data  = 8'h5A;
        reg_enable  = 9'b000_100_000;
        #1;
        total_cnt++; if (bus1 !== 8'h5A) $display("FAIL latch_bus1 got %h want 5a", bus1); else pass_cnt++;
        total_cnt++; if (reg_out !== 24'h000000) $display("FAIL latch_before_edge got %h want 000000", reg_out); else pass_cnt++;
        step();
        total_cnt++; if (reg_out !== 24'h005A00) $display("FAIL latch_load got %h want 005a00", reg_out); else pass_cnt++;
        total_cnt++; if (phase !== exp_phase) $display("FAIL latch_phase got %b want %b", phase, exp_phase); else pass_cnt++;
        total_cnt++; if (pc !== RST_PC) $display("FAIL latch_pc_hold got %h want %h", pc, RST_PC); else pass_cnt++;
    endtask

    task automatic test_copy_alu();
        latch_data = 8'h33;
        reg_enable = 9'b000_000_100;
        step();
        total_cnt++; if (reg_out !== 24'h005A33) $display("FAIL preload_reg0 got %h want 005a33", reg_out); else pass_cnt++;
        latch_valid = 1'b0;
        alu_valid   = 1'b1;
        alu_result  = 8'hC4;
        reg_enable  = 9'b100_101_110;
        #1;
        total_cnt++; if (bus1 !== 8'h33) $display("FAIL copy_bus1 got %h want 33", bus1); else pass_cnt++;
        total_cnt++; if (bus2 !== 8'hC4) $display("FAIL copy_bus2 got %h want c4", bus2); else pass_cnt++;
        step();
        total_cnt++; if (reg_out !== 24'h33C433) $display("FAIL copy_alu got %h want 33c433", reg_out); else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_pc_ops();
        latch_valid = 1'b1; latch_data = 8'hFF;
        alu_valid   = 1'b1; alu_result = 8'hFF;
        pc_op       = 2'b10;
        step();
        total_cnt++; if (pc !== 16'hFFFF) $display("FAIL pc_load_ffff got %h want ffff", pc); else pass_cnt++;
        idle_inputs();
        pc_op = 2'b01;
        step();
        total_cnt++; if (pc !== 16'h0000) $display("FAIL pc_inc_wrap got %h want 0000", pc); else pass_cnt++;
        latch_valid = 1'b1; latch_data = 8'h00;
        alu_valid   = 1'b1; alu_result = 8'h10;
        pc_op       = 2'b10;
        step();
        total_cnt++; if (pc !== 16'h1000) $display("FAIL pc_load_1000 got %h want 1000", pc); else pass_cnt++;
        alu_valid  = 1'b0;
        latch_data = 8'hFE;
        pc_op      = 2'b11;
        step();
        total_cnt++; if (pc !== 16'h0FFE) $display("FAIL pc_rel_neg got %h want 0ffe", pc); else pass_cnt++;
        alu_valid  = 1'b1; alu_result = 8'h12;
        latch_data = 8'h34;
        pc_op      = 2'b10;
        step();
        total_cnt++; if (pc !== 16'h1234) $display("FAIL pc_load_1234 got %h want 1234", pc); else pass_cnt++;
        alu_valid  = 1'b0;
        latch_data = 8'h05;
        pc_op      = 2'b11;
        step();
        total_cnt++; if (pc !== 16'h1239) $display("FAIL pc_rel_pos got %h want 1239", pc); else pass_cnt++;
        // Register store onto bus1 feeds the relative add: reg0 = 0x33.
        latch_valid = 1'b0;
        reg_enable  = 9'b000_000_110;
        step();
        total_cnt++; if (pc !== 16'h126C) $display("FAIL pc_rel_reg got %h want 126c", pc); else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_pin_mux();
        latch_valid = 1'b1; latch_data = 8'hCD;
        alu_valid   = 1'b1; alu_result = 8'hAB;
        pc_op       = 2'b10;
        step();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++; if (phase !== exp_phase) $display("FAIL pin_phase[%0d] got %b want %b", i, phase, exp_phase); else pass_cnt++;
            total_cnt++; if (addr_pins !== (exp_phase ? 8'hAB : 8'hCD)) $display("FAIL pin_addr[%0d] got %h want %h", i, addr_pins, exp_phase ? 8'hAB : 8'hCD); else pass_cnt++;
        end
        clk_enable  = 1'b0;
        pc_op       = 2'b01;
        reg_enable  = 9'b100_100_100;
        latch_valid = 1'b1; latch_data = 8'h99;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++; if (phase !== exp_phase) $display("FAIL pin_frozen[%0d] got %b want %b", i, phase, exp_phase); else pass_cnt++;
        end
        total_cnt++; if (pc !== 16'hABCD) $display("FAIL hold_pc got %h want abcd", pc); else pass_cnt++;
        total_cnt++; if (reg_out !== 24'h33C433) $display("FAIL hold_regs got %h want 33c433", reg_out); else pass_cnt++;
        total_cnt++; if (bus1 !== 8'h99) $display("FAIL hold_bus_comb got %h want 99", bus1); else pass_cnt++;
        idle_inputs();
        clk_enable = 1'b1;
    endtask

    task automatic test_contention();
        latch_valid = 1'b1; latch_data = 8'h99;
        reg_enable  = 9'b000_000_110;
        #1;
        total_cnt++; if (bus1 !== 8'h99) $display("FAIL latch_priority got %h want 99", bus1); else pass_cnt++;
        latch_valid = 1'b0;
        reg_enable  = 9'b111_111_000;
        #1;
        total_cnt++; if (bus2 !== 8'hC4) $display("FAIL bus2_lowest got %h want c4", bus2); else pass_cnt++;
        reg_enable = 9'b110_110_100;
        #1;
        total_cnt++; if (bus1 !== 8'hC4) $display("FAIL bus1_lowest got %h want c4", bus1); else pass_cnt++;
        step();
        total_cnt++; if (reg_out !== 24'h33C4C4) $display("FAIL contend_load got %h want 33c4c4", reg_out); else pass_cnt++;
        total_cnt++; if (contention !== EXP_CONT) $display("FAIL contention_set got %b want %b", contention, EXP_CONT); else pass_cnt++;
        idle_inputs();
        step();
        step();
        total_cnt++; if (contention !== EXP_CONT) $display("FAIL contention_sticky got %b want %b", contention, EXP_CONT); else pass_cnt++;
    endtask

    task automatic test_reset_mid_transfer();
        clk_enable  = 1'b0;
        rst_n       = 1'b0;
        reg_enable  = 9'b100_100_100;
        latch_valid = 1'b1; latch_data = 8'h77;
        pc_op       = 2'b01;
        step();
        rst_n = 1'b1;
        idle_inputs();
        #1;
        total_cnt++; if (reg_out !== 24'h000000) $display("FAIL mid_reset_regs got %h want 000000", reg_out); else pass_cnt++;
        total_cnt++; if (pc !== RST_PC) $display("FAIL mid_reset_pc got %h want %h", pc, RST_PC); else pass_cnt++;
        total_cnt++; if (phase !== 1'b0 || addr_pins !== 8'hFC) $display("FAIL mid_reset_pins got %b/%h want 0/fc", phase, addr_pins); else pass_cnt++;
        total_cnt++; if (contention !== 1'b0) $display("FAIL mid_reset_contention got %b want 0", contention); else pass_cnt++;
        clk_enable = 1'b1;
        step();
        total_cnt++; if (phase !== 1'b1 || addr_pins !== 8'hFF) $display("FAIL post_reset_pins got %b/%h want 1/ff", phase, addr_pins); else pass_cnt++;
    endtask

    initial begin
        rst_n      = 1'b1;
        clk_enable = 1'b0;
        idle_inputs();
        test_reset();
        test_latch_load();
        test_copy_alu();
        test_pc_ops();
        test_pin_mux();
        test_contention();
        test_reset_mid_transfer();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_bus_fabric.md
# regfile_bus_fabric

Parametrised successor to the 6502 core's hard-wired accumulator/X/Y register block and two-bus datapath. It holds `NUM_REGS` general registers of `WIDTH` bits and a `2*WIDTH`-bit program counter. It also implements the two internal buses (bus1, bus2) with fixed-priority source selection and the time-multiplexed address pin output. It sits between instruction decode (which drives per-register enable codes and the PC op) and the ALU (which consumes bus1/bus2 and returns a result).

## Interface
Parameters:
- `WIDTH`, 8, register and bus width; address width is `2*WIDTH`
- `NUM_REGS`, 3, number of general registers (index 0 = accumulator, 1 = X, 2 = Y); legal range 1..8
- `RESET_PC`, 0, PC value loaded on reset

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous active-low reset: one clock, reset sampled on `posedge clk`, active low
- `clk_enable`  in  1  advance strobe; state updates only when high
- `reg_enable`  in  `3*NUM_REGS`  per-register 3-bit code; register i uses bits `[3i+2:3i]`
- `latch_valid`  in  1  input data latch drives bus1
- `latch_data`  in  `WIDTH`  input data latch value
- `alu_valid`  in  1  ALU result drives bus2
- `alu_result`  in  `WIDTH`  ALU result
- `pc_op`  in  2  PC operation: 00 hold, 01 increment, 10 load `{bus2,bus1}`, 11 relative add of bus1
- `bus1`  out  `WIDTH`  internal bus 1 (combinational)
- `bus2`  out  `WIDTH`  internal bus 2 (combinational)
- `reg_out`  out  `NUM_REGS*WIDTH`  flattened register contents; register i at `[WIDTH*i +: WIDTH]`
- `pc`  out  `2*WIDTH`  program counter
- `phase`  out  1  pin phase; 0 = low address half, 1 = high address half
- `addr_pins`  out  `WIDTH`  `phase ? pc[2W-1:W] : pc[W-1:0]`
- `contention`  out  1  sticky bus-contention flag; tied 0 when the feature is compiled out

## Operation
- Register codes: `000` idle, `100` load from bus1, `101` load from bus2, `110` store onto bus1, `111` store onto bus2. Codes `001`–`011` are treated as idle.
- bus1 source priority: `latch_valid`, then the lowest-index register with code `110`, else 0.
- bus2 source priority: `alu_valid`, then the lowest-index register with code `111`, else 0.
- Register transfers: a register with a load code captures the selected bus value. Reg→reg transfer in one step is legal, e.g. reg0=`110` and reg2=`100` copies reg0 into reg2.
- PC increment: +1 modulo 2^(2W). `FFFF`→`0000` at W=8.
- PC load: captures `{bus2, bus1}`; bus2 is the high half.
- PC relative add: `pc + sign_extend(bus1)` modulo 2^(2W).
- Register loads and PC update happen in the same step. The PC sees the same bus values as the registers.
- `phase` toggles every enabled step.
- Reset values: all registers 0, `pc = RESET_PC`, `phase = 0`, `contention = 0`.
- `addr_pins` after reset is `RESET_PC[W-1:0]`. `bus1` and `bus2` after reset are 0 unless an external valid input is high.

## Timing
- All state updates on `posedge clk` when `clk_enable = 1`. With `clk_enable = 0`, all state holds and buses remain combinational.
- Reset has priority over `clk_enable`. A reset asserted mid-transfer discards that step's loads and PC op.
- Latency: a bus value is visible in `reg_out`/`pc` one enabled edge after the load code is presented. Buses and `addr_pins` respond combinationally within the same cycle.
- No handshake. Decode guarantees the codes are stable across the enabled edge.

## Configuration
- `REGFILE_CONTENTION_DETECT_EN` defined:
  - `contention` is set on any enabled edge where two or more sources would drive the same bus (both external valid and register store, or multiple register stores).
  - It is sticky until reset.
  - Priority selection is unchanged.
- `REGFILE_CONTENTION_DETECT_EN` undefined: `contention` is constant 0 and no detection logic is built.

## Test plan
- **Reset:** `rst_n = 0` for one enabled edge, then release -> regs 0, `pc = RESET_PC`, `phase = 0`, `addr_pins = RESET_PC` low byte.
- **Latch to register:** `latch_valid = 1`, `latch_data = 8'h5A`, reg1 code `100`, one enabled edge -> `reg_out[15:8] = 8'h5A`, others unchanged.
- **Register copy and ALU load:** reg0 = `8'h33`, reg0 `110`, reg2 `100`, reg1 `101`, `alu_valid = 1`, `alu_result = 8'hC4` -> reg2 = `8'h33`, reg1 = `8'hC4`.
- **PC wrap, relative add, load:**
  - `pc = 16'hFFFF`, op 01 -> `16'h0000`.
  - `pc = 16'h1000`, bus1 = `8'hFE`, op 11 -> `16'h0FFE`.
  - bus2 = `8'h12`, bus1 = `8'h34`, op 10 -> `16'h1234`.
- **Pin mux:** `pc = 16'hABCD` held, `clk_enable` toggling -> `addr_pins` alternates `8'hCD`/`8'hAB` with `phase` 0/1. With `clk_enable = 0`, `phase` is frozen.
- **Contention (macro on):** reg0 and reg1 both `110` -> bus1 = reg0 value, `contention = 1` after the edge, stays 1 with idle codes until reset. Macro off: same stimulus -> `contention = 0`.
